// File: rtl/fpu_result_collector_if.sv
// Handshake and status bundle between the FPU result collector and its producer/consumer.
// The slave modport is the collector side; the master modport is the FPU/consumer side.
interface fpu_result_collector_if #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned STATUS_W = 4,
  parameter int unsigned CNT_W    = 8
);
  localparam int unsigned OccW = $clog2(DEPTH) + 1;

  logic [31:0]         data_in;
  logic [STATUS_W-1:0] status_in;
  logic                valid_in;
  logic [31:0]         out_data;
  logic [STATUS_W-1:0] out_status;
  logic                out_valid;
  logic                out_ready;
  logic                fifo_full;
  logic                fifo_empty;
  logic [OccW-1:0]     occupancy;
  logic                clear_counts;
  logic [CNT_W-1:0]    ovf_count;
  logic [CNT_W-1:0]    unf_count;
  logic [CNT_W-1:0]    drop_count;

  modport slave (
    input  data_in, status_in, valid_in, out_ready, clear_counts,
    output out_data, out_status, out_valid, fifo_full, fifo_empty, occupancy,
           ovf_count, unf_count, drop_count
  );

  modport master (
    output data_in, status_in, valid_in, out_ready, clear_counts,
    input  out_data, out_status, out_valid, fifo_full, fifo_empty, occupancy,
           ovf_count, unf_count, drop_count
  );
endinterface

// File: rtl/fpu_result_collector.sv
// First-word-fall-through buffer for FPU results with saturating overflow, underflow and
// drop event counters.
module fpu_result_collector #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned STATUS_W = 4,
  parameter int unsigned CNT_W    = 8
) (
  input logic                  clock_100Khz,
  input logic                  reset,
  fpu_result_collector_if.slave bus
);
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned OccW   = PtrW + 1;
  localparam int unsigned EntryW = 32 + STATUS_W;

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [EntryW-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]   occ_q, occ_d;
  logic [CNT_W-1:0]  ovf_q, ovf_d;
  logic [CNT_W-1:0]  unf_q, unf_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic full, empty, push, pop, drop;
  logic [EntryW-1:0] head;

  always_comb begin
    full  = (occ_q == OccW'(DEPTH));
    empty = (occ_q == '0);
    pop   = ~empty & bus.out_ready;
    // A full buffer still accepts a result when the head leaves in the same cycle.
    push  = bus.valid_in & (~full | pop);
    drop  = bus.valid_in & full & ~pop;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = {bus.data_in, bus.status_in};
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    drop_d = drop_q;
    if (bus.clear_counts) begin
      ovf_d  = '0;
      unf_d  = '0;
      drop_d = '0;
    end else begin
      if (push && bus.status_in[1] && (ovf_q != '1)) ovf_d = ovf_q + CNT_W'(1);
      if (push && bus.status_in[2] && (unf_q != '1)) unf_d = unf_q + CNT_W'(1);
      if (drop && (drop_q != '1))                    drop_d = drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_100Khz) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= '0;
      unf_q    <= '0;
      drop_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      drop_q   <= drop_d;
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign bus.out_data   = head[EntryW-1:STATUS_W];
  assign bus.out_status = head[STATUS_W-1:0];
  assign bus.out_valid  = ~empty;
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
  assign bus.occupancy  = occ_q;
  assign bus.ovf_count  = ovf_q;
  assign bus.unf_count  = unf_q;
  assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_fpu_result_collector.sv
// Directed bench for fpu_result_collector: reset, FWFT latency, fill/drop, full push+pop,
// flag counters with clear, saturation and mid-stream reset.
`timescale 1ns/1ps
module tb_fpu_result_collector;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fpu_result_collector_if #(.DEPTH(4), .STATUS_W(4), .CNT_W(8)) bus ();

  fpu_result_collector #(.DEPTH(4), .STATUS_W(4), .CNT_W(8)) dut (
    .clock_100Khz (clk),
    .reset        (reset),
    .bus          (bus)
  );

  logic [31:0] vals [5] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                            32'h4080_0000, 32'h40A0_0000};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.data_in      = '0;
    bus.status_in    = '0;
    bus.valid_in     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.clear_counts = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (bus.occupancy !== 3'd0) begin errors++;
      $display("FAIL reset_occ got %0d want 0", bus.occupancy); end
    checks++; if ({bus.out_valid, bus.fifo_empty, bus.fifo_full} !== 3'b010) begin errors++;
      $display("FAIL reset_flags got %b want 010", {bus.out_valid, bus.fifo_empty, bus.fifo_full}); end
    checks++; if ({bus.out_data, bus.out_status} !== 36'h0) begin errors++;
      $display("FAIL reset_head got %h want 0", {bus.out_data, bus.out_status}); end
    checks++; if ({bus.ovf_count, bus.unf_count, bus.drop_count} !== 24'h0) begin errors++;
      $display("FAIL reset_counts got %h want 0", {bus.ovf_count, bus.unf_count, bus.drop_count}); end
  endtask

  task automatic test_single();
    bus.data_in   = 32'h40C0_0000;
    bus.status_in = 4'b0001;
    bus.valid_in  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.valid_in = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.occupancy !== 3'd1) begin errors++;
      $display("FAIL single_valid got v=%b occ=%0d want v=1 occ=1", bus.out_valid, bus.occupancy); end
    checks++; if (bus.out_data !== 32'h40C0_0000 || bus.out_status !== 4'b0001) begin errors++;
      $display("FAIL single_data got %h/%b want 40c00000/0001", bus.out_data, bus.out_status); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.fifo_empty !== 1'b1) begin errors++;
      $display("FAIL single_pop got v=%b e=%b want v=0 e=1", bus.out_valid, bus.fifo_empty); end
  endtask

  task automatic test_fill_drop();
    for (int i = 0; i < 5; i++) begin
      bus.data_in  = vals[i];
      bus.valid_in = 1'b1;
      tick();
    end
    bus.valid_in = 1'b0;
    checks++; if (bus.fifo_full !== 1'b1 || bus.occupancy !== 3'd4) begin errors++;
      $display("FAIL fill_full got f=%b occ=%0d want f=1 occ=4", bus.fifo_full, bus.occupancy); end
    checks++; if (bus.drop_count !== 8'd1) begin errors++;
      $display("FAIL fill_drop got %0d want 1", bus.drop_count); end
    tick();
    checks++; if (bus.out_data !== vals[0]) begin errors++;
      $display("FAIL fill_head_stable got %h want %h", bus.out_data, vals[0]); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== vals[i]) begin errors++;
        $display("FAIL drain_%0d got v=%b %h want v=1 %h", i, bus.out_valid, bus.out_data, vals[i]); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    checks++; if (bus.fifo_empty !== 1'b1 || bus.occupancy !== 3'd0) begin errors++;
      $display("FAIL drain_empty got e=%b occ=%0d want e=1 occ=0", bus.fifo_empty, bus.occupancy); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_d [4];
    exp_d = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h4100_0000};
    for (int i = 0; i < 4; i++) begin
      bus.data_in  = vals[i];
      bus.valid_in = 1'b1;
      tick();
    end
    bus.data_in   = 32'h4100_0000;
    bus.out_ready = 1'b1;
    tick();
    bus.valid_in  = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (bus.occupancy !== 3'd4 || bus.fifo_full !== 1'b1) begin errors++;
      $display("FAIL pushpop_occ got %0d f=%b want 4 f=1", bus.occupancy, bus.fifo_full); end
    checks++; if (bus.drop_count !== 8'd1) begin errors++;
      $display("FAIL pushpop_drop got %0d want 1", bus.drop_count); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_data !== exp_d[i]) begin errors++;
        $display("FAIL pushpop_drain_%0d got %h want %h", i, bus.out_data, exp_d[i]); end
      tick();
    end
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL pushpop_empty got v=%b want 0", bus.out_valid); end
  endtask

  task automatic test_flags_clear();
    bus.out_ready = 1'b1;
    bus.valid_in  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.data_in   = 32'h7F80_0000;
      bus.status_in = (i < 3) ? 4'b0010 : 4'b0100;
      tick();
    end
    checks++; if (bus.ovf_count !== 8'd3 || bus.unf_count !== 8'd2) begin errors++;
      $display("FAIL flags_count got ovf=%0d unf=%0d want 3 2", bus.ovf_count, bus.unf_count); end
    bus.status_in = 4'b0110;
    tick();
    checks++; if (bus.ovf_count !== 8'd4 || bus.unf_count !== 8'd3 || bus.drop_count !== 8'd1)
      begin errors++;
      $display("FAIL flags_both got %0d %0d %0d want 4 3 1",
               bus.ovf_count, bus.unf_count, bus.drop_count); end
    bus.status_in    = 4'b0010;
    bus.clear_counts = 1'b1;
    tick();
    bus.clear_counts = 1'b0;
    bus.valid_in     = 1'b0;
    checks++; if ({bus.ovf_count, bus.unf_count, bus.drop_count} !== 24'h0) begin errors++;
      $display("FAIL flags_clear got %h want 0", {bus.ovf_count, bus.unf_count, bus.drop_count}); end
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++;
      $display("FAIL flags_drained got e=%b want 1", bus.fifo_empty); end
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b1;
    bus.valid_in  = 1'b1;
    bus.status_in = 4'b0010;
    bus.data_in   = 32'h7F80_0000;
    for (int i = 0; i < 300; i++) tick();
    checks++; if (bus.ovf_count !== 8'hFF) begin errors++;
      $display("FAIL sat_ovf got %0d want 255", bus.ovf_count); end
    checks++; if (bus.occupancy !== 3'd1 || bus.drop_count !== 8'd0 || bus.unf_count !== 8'd0)
      begin errors++;
      $display("FAIL sat_stream got occ=%0d drop=%0d unf=%0d want 1 0 0",
               bus.occupancy, bus.drop_count, bus.unf_count); end
    tick();
    bus.valid_in = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.ovf_count !== 8'hFF || bus.fifo_empty !== 1'b1) begin errors++;
      $display("FAIL sat_hold got %0d e=%b want 255 e=1", bus.ovf_count, bus.fifo_empty); end
  endtask

  task automatic test_reset_mid();
    bus.status_in = 4'b0110;
    bus.valid_in  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data_in = vals[i];
      tick();
    end
    checks++; if (bus.occupancy !== 3'd3) begin errors++;
      $display("FAIL mid_pre_occ got %0d want 3", bus.occupancy); end
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    bus.data_in   = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0;
    idle_inputs();
    checks++; if (bus.occupancy !== 3'd0 || bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL mid_occ got %0d v=%b want 0 v=0", bus.occupancy, bus.out_valid); end
    checks++; if ({bus.ovf_count, bus.unf_count, bus.drop_count} !== 24'h0) begin errors++;
      $display("FAIL mid_counts got %h want 0", {bus.ovf_count, bus.unf_count, bus.drop_count}); end
    checks++; if ({bus.out_data, bus.out_status} !== 36'h0) begin errors++;
      $display("FAIL mid_head got %h want 0", {bus.out_data, bus.out_status}); end
    test_single();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drop();
    test_full_push_pop();
    test_flags_clear();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
